// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default oversample ratio and
// frame helpers used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_state_t;

  localparam int OVERSAMPLE_DEFAULT = 8;

  function automatic logic [3:0] data_bits(input logic [1:0] length);
    return 4'd6 + 4'(length);
  endfunction

  // Parity over the configured data bits only; odd=1 inverts for odd parity.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] length,
                                      input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 9; i++) begin
      if (i < int'(data_bits(length))) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Bus-side signal bundle of the UART transmitter: tick, frame config,
// holding-register write port and line/status outputs.
interface uart_tx_if;
  logic       i_ce;
  logic       i_rst_err;
  logic [1:0] i_length;
  logic       i_stop2;
  logic       i_parity;
  logic       i_odd;
  logic [8:0] i_data;
  logic       i_we;
  logic       o_tx;
  logic       o_full;
  logic       o_busy;
  logic       o_write_err;

  modport master (
    output i_ce, i_rst_err, i_length, i_stop2, i_parity, i_odd, i_data, i_we,
    input  o_tx, o_full, o_busy, o_write_err
  );

  modport slave (
    input  i_ce, i_rst_err, i_length, i_stop2, i_parity, i_odd, i_data, i_we,
    output o_tx, o_full, o_busy, o_write_err
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding register; serialises 6..9-bit
// words with optional parity and one or two stop bits, timed by i_ce ticks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input logic      i_clk,
  input logic      i_rst,
  uart_tx_if.slave bus
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  uart_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       idx_reg, idx_next;
  logic [8:0]       shift_reg, shift_next;
  logic [8:0]       hr_reg, hr_next;
  logic             full_reg, full_next;
  logic             err_reg, err_next;
  logic             tx_reg, tx_next;
  logic [1:0]       len_reg, len_next;
  logic             stop2_reg, stop2_next;
  logic             par_en_reg, par_en_next;
  logic             par_reg, par_next;
  logic             wrap;
  logic             frame_end;
  logic             start_frame;
  logic             hr_free;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      hr_reg     <= '0;
      full_reg   <= 1'b0;
      err_reg    <= 1'b0;
      tx_reg     <= 1'b1;
      len_reg    <= '0;
      stop2_reg  <= 1'b0;
      par_en_reg <= 1'b0;
      par_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      hr_reg     <= hr_next;
      full_reg   <= full_next;
      err_reg    <= err_next;
      tx_reg     <= tx_next;
      len_reg    <= len_next;
      stop2_reg  <= stop2_next;
      par_en_reg <= par_en_next;
      par_reg    <= par_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    hr_next     = hr_reg;
    full_next   = full_reg;
    err_next    = err_reg;
    tx_next     = tx_reg;
    len_next    = len_reg;
    stop2_next  = stop2_reg;
    par_en_next = par_en_reg;
    par_next    = par_reg;

    wrap        = bus.i_ce && (cnt_reg == CNT_LAST);
    frame_end   = wrap && (((state_reg == STOP1) && !stop2_reg) || (state_reg == STOP2));
    start_frame = bus.i_ce && full_reg && ((state_reg == IDLE) || frame_end);
    hr_free     = !full_reg || start_frame;

    if (bus.i_ce && (state_reg != IDLE)) cnt_next = wrap ? '0 : cnt_reg + 1'b1;

    // tx_next always carries the line level of the state being entered
    case (state_reg)
      START: begin
        if (wrap) begin
          state_next = DATA;
          idx_next   = '0;
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
        end
      end
      DATA: begin
        if (wrap) begin
          if (idx_reg == data_bits(len_reg) - 4'd1) begin
            state_next = par_en_reg ? PARITY : STOP1;
            tx_next    = par_en_reg ? par_reg : 1'b1;
          end else begin
            idx_next   = idx_reg + 4'd1;
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (wrap) begin
          state_next = STOP1;
          tx_next    = 1'b1;
        end
      end
      STOP1: begin
        if (wrap && stop2_reg) begin
          state_next = STOP2;
          tx_next    = 1'b1;
        end
      end
      default: ;
    endcase

    if (frame_end) begin
      state_next = IDLE;
      tx_next    = 1'b1;
    end

    // Frame start (from IDLE or straight after the last stop bit) wins
    if (start_frame) begin
      state_next  = START;
      tx_next     = 1'b0;
      cnt_next    = '0;
      shift_next  = hr_reg;
      len_next    = bus.i_length;
      stop2_next  = bus.i_stop2;
      par_en_next = bus.i_parity;
      par_next    = parity_bit(hr_reg, bus.i_length, bus.i_odd);
    end

    if (bus.i_we) begin
      if (hr_free) begin
        hr_next   = bus.i_data;
        full_next = 1'b1;
      end
    end else if (start_frame) begin
      full_next = 1'b0;
    end

    if (bus.i_we && !hr_free) err_next = 1'b1;
    else if (bus.i_rst_err) err_next = 1'b0;
  end

  assign bus.o_tx        = tx_reg;
  assign bus.o_full      = full_reg;
  assign bus.o_busy      = (state_reg != IDLE);
  assign bus.o_write_err = err_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected frames are queued on write and a
// line monitor decodes o_tx per i_ce pulse and compares against the queue.
module tb_uart_tx;
  localparam int OS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if bus ();

  uart_tx #(.OVERSAMPLE(OS)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [12:0] bits;
    int          n;
    logic [8:0]  data;
  } frame_t;

  frame_t exp_q[$];
  int compared    = 0;
  int mismatched  = 0;
  int ce_mode     = 0;   // 0 always, 1 toggle, 2 random, 3 held low
  int abut_cnt    = 0;
  int frames_done = 0;
  bit mon_in_frame = 1'b0;

  logic [1:0] cfg_len;
  logic       cfg_par, cfg_odd, cfg_stop2;

  // Expected line bits, one entry per bit period, start bit first
  function automatic frame_t make_frame(input logic [8:0] d);
    frame_t f;
    logic p;
    f.bits = '1;
    f.n    = 0;
    f.data = d;
    f.bits[f.n] = 1'b0; f.n++;
    p = cfg_odd;
    for (int i = 0; i < 6 + int'(cfg_len); i++) begin
      f.bits[f.n] = d[i]; f.n++;
      p = p ^ d[i];
    end
    if (cfg_par) begin f.bits[f.n] = p; f.n++; end
    f.bits[f.n] = 1'b1; f.n++;
    if (cfg_stop2) begin f.bits[f.n] = 1'b1; f.n++; end
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic set_cfg(input logic [1:0] len, input logic par, input logic odd, input logic st2);
    cfg_len = len; cfg_par = par; cfg_odd = odd; cfg_stop2 = st2;
    bus.i_length = len; bus.i_parity = par; bus.i_odd = odd; bus.i_stop2 = st2;
  endtask

  task automatic write(input logic [8:0] d, input bit accept);
    @(posedge clk); #1;
    bus.i_we   = 1'b1;
    bus.i_data = d;
    if (accept) exp_q.push_back(make_frame(d));
    @(posedge clk); #1;
    bus.i_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 5000) begin
      @(negedge clk); #1;
      if (!mon_in_frame && exp_q.size() == 0 && !bus.o_full && !bus.o_busy) break;
      n++;
    end
    if (n >= 5000) begin
      compared++; mismatched++;
      $display("FAIL wait_idle: got timeout after %0d clocks, want idle", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_full_clear();
    int n;
    n = 0;
    while (bus.o_full !== 1'b0 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      compared++; mismatched++;
      $display("FAIL wait_full_clear: got timeout, want o_full=0");
    end
  endtask

  // Oversample tick generator
  initial begin
    bus.i_ce = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (ce_mode)
        0:       bus.i_ce = 1'b1;
        1:       bus.i_ce = ~bus.i_ce;
        2:       bus.i_ce = 1'($urandom_range(0, 1));
        default: bus.i_ce = 1'b0;
      endcase
    end
  end

  // Line monitor: one sample per i_ce pulse, compared with the queued frame
  initial begin
    frame_t cur;
    int idx, bad;
    bit just_ended, unexp_seen;
    logic ce_s, rst_s, last_tx;
    logic [12:0] cap;
    idx = 0; bad = 0; just_ended = 0; unexp_seen = 0; last_tx = 1'b1; cap = '1;
    forever begin
      @(posedge clk);
      ce_s  = bus.i_ce;
      rst_s = rst;
      @(negedge clk);
      if (rst_s) begin
        mon_in_frame = 1'b0;
        exp_q.delete();
        just_ended = 0;
      end else if (!ce_s) begin
        if (bus.o_tx !== last_tx) begin
          compared++; mismatched++;
          $display("FAIL tx_stable: got %b without i_ce, want %b", bus.o_tx, last_tx);
        end
      end else begin
        if (!mon_in_frame) begin
          if (bus.o_tx === 1'b0) begin
            if (exp_q.size() == 0) begin
              if (!unexp_seen) begin
                compared++; mismatched++;
                $display("FAIL unexpected_frame: got start bit, want idle line");
              end
              unexp_seen = 1;
            end else begin
              cur = exp_q.pop_front();
              mon_in_frame = 1'b1;
              idx = 0; bad = 0; cap = '1;
              if (just_ended) abut_cnt++;
            end
          end else begin
            unexp_seen = 0;
            if (just_ended) begin
              compared++;
              if (bus.o_busy !== 1'b0) begin
                mismatched++;
                $display("FAIL busy_fall: got o_busy=%b after last stop, want 0", bus.o_busy);
              end
            end
          end
          just_ended = 0;
        end
        if (mon_in_frame) begin
          if (idx % OS == OS / 2) cap[idx / OS] = bus.o_tx;
          if (bus.o_tx !== cur.bits[idx / OS] || bus.o_busy !== 1'b1) bad++;
          idx++;
          if (idx == cur.n * OS) begin
            compared++;
            if (bad != 0) begin
              mismatched++;
              $display("FAIL frame data=0x%03h: got bits %b want %b (%0d bad samples)",
                       cur.data, cap, cur.bits, bad);
            end else begin
              $display("frame %0d data=0x%03h bits=%0d ok", frames_done, cur.data, cur.n);
            end
            mon_in_frame = 1'b0;
            just_ended = 1;
            frames_done++;
          end
        end
      end
      last_tx = bus.o_tx;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] d;
    int prev, cnt;
    bus.i_we = 1'b0; bus.i_data = '0; bus.i_rst_err = 1'b0;
    set_cfg(2'd0, 1'b0, 1'b0, 1'b0);
    ce_mode = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_out", {bus.o_tx, bus.o_busy, bus.o_full, bus.o_write_err}, 4'b1000);
    repeat (50) begin
      @(negedge clk);
      check("idle_out", {bus.o_tx, bus.o_busy, bus.o_full}, 3'b100);
    end

    // 9 data bits, odd parity, two stop bits: 104 pulses
    @(posedge clk); #1;
    set_cfg(2'd3, 1'b1, 1'b1, 1'b1);
    prev = frames_done;
    write(9'b101010101, 1);
    wait_idle();
    check("frame9_count", frames_done, prev + 1);

    // Back-to-back 6-bit frames
    set_cfg(2'd0, 1'b0, 1'b0, 1'b0);
    prev = abut_cnt;
    write(9'h02A, 1);
    wait_full_clear();
    write(9'h015, 1);
    @(negedge clk);
    check("b2b_full", bus.o_full, 1'b1);
    wait_idle();
    check("b2b_abut", abut_cnt, prev + 1);

    // Frozen tick: drop, error flag, clear priority, then write latency
    set_cfg(2'd2, 1'b1, 1'b0, 1'b0);
    ce_mode = 3;
    write(9'h0A5, 1);
    write(9'h05A, 0);
    @(negedge clk);
    check("drop_state", {bus.o_write_err, bus.o_full, bus.o_busy, bus.o_tx}, 4'b1101);
    @(posedge clk); #1 bus.i_rst_err = 1'b1;
    @(posedge clk); #1 bus.i_rst_err = 1'b0;
    @(negedge clk);
    check("err_clear", bus.o_write_err, 1'b0);
    @(posedge clk); #1;
    bus.i_we = 1'b1; bus.i_data = 9'h1FF; bus.i_rst_err = 1'b1;
    @(posedge clk); #1;
    bus.i_we = 1'b0; bus.i_rst_err = 1'b0;
    @(negedge clk);
    check("err_set_priority", bus.o_write_err, 1'b1);
    @(posedge clk); #1 bus.i_rst_err = 1'b1;
    @(posedge clk); #1 bus.i_rst_err = 1'b0;
    ce_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("latency_start", {bus.o_tx, bus.o_busy, bus.o_full, bus.o_write_err}, 4'b0100);
    wait_idle();

    // Three writes while busy: third dropped
    set_cfg(2'd1, 1'b1, 1'b0, 1'b0);
    prev = abut_cnt;
    write(9'h033, 1);
    wait_full_clear();
    write(9'h04C, 1);
    write(9'h011, 0);
    @(negedge clk);
    check("three_writes_err", bus.o_write_err, 1'b1);
    @(posedge clk); #1 bus.i_rst_err = 1'b1;
    @(posedge clk); #1 bus.i_rst_err = 1'b0;
    @(negedge clk);
    check("three_writes_clear", bus.o_write_err, 1'b0);
    wait_idle();
    check("three_writes_abut", abut_cnt, prev + 1);

    // Tick every other clock: 10 bits x 16 clocks of busy
    set_cfg(2'd1, 1'b0, 1'b0, 1'b1);
    ce_mode = 1;
    write(9'h05D, 1);
    cnt = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (bus.o_busy) cnt++;
      else if (cnt > 0) break;
    end
    check("toggle_busy_clocks", cnt, 160);
    wait_idle();

    // Randomised frames and configs
    for (int it = 0; it < 24; it++) begin
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ce_mode = $urandom_range(0, 2);
      prev = frames_done;
      d = 9'($urandom);
      write(d, 1);
      cnt = 1;
      if ($urandom_range(0, 1) == 1) begin
        wait_full_clear();
        d = 9'($urandom);
        write(d, 1);
        cnt = 2;
      end
      wait_idle();
      check("rand_frame_count", frames_done, prev + cnt);
    end

    // Reset in the middle of DATA with the holding register full
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    ce_mode = 0;
    write(9'h1C3, 1);
    wait_full_clear();
    write(9'h0F0, 1);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_out", {bus.o_tx, bus.o_busy, bus.o_full}, 3'b100);
    prev = frames_done;
    repeat (200) @(negedge clk);
    check("midreset_no_resume", {bus.o_tx, bus.o_busy, bus.o_full}, 3'b100);
    check("midreset_frames", frames_done, prev);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter with a one-entry holding register, the line-side counterpart of `uart_rx`. It accepts 6–9-bit words from the peripheral bus register file and serialises them on `o_tx`. Frames carry optional even/odd parity and one or two stop bits. It uses the same `i_ce` oversampling tick and the same frame configuration inputs as `uart_rx`, so a loopback of `o_tx` into `uart_rx` round-trips data.

## Interface
- `OVERSAMPLE`, default 8: `i_ce` pulses per bit period. Must match `uart_rx`.
- `i_clk` in 1: single clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_ce` in 1: oversample tick. All bit timing advances only on clocks where `i_ce`=1.
- `i_rst_err` in 1: clears `o_write_err`.
- `i_length` in 2: data bits = 6 + `i_length` (6, 7, 8 or 9).
- `i_stop2` in 1: 1 selects two stop bits.
- `i_parity` in 1: 1 enables the parity bit.
- `i_odd` in 1: 1 selects odd parity, 0 selects even.
- `i_data` in 9: word to send. Bits above the configured length are ignored.
- `i_we` in 1: write strobe for the holding register.
- `o_tx` out 1: serial line. Idles high.
- `o_full` out 1: holding register occupied.
- `o_busy` out 1: frame in progress (state ≠ IDLE).
- `o_write_err` out 1: sticky flag, set when a write is dropped.

## Operation
- Holding register (HR): `i_we` with `o_full`=0 loads HR and sets `o_full` on the same edge.
  - `i_we` with `o_full`=1: write is dropped, HR unchanged, `o_write_err` set.
  - The set has priority over a simultaneous `i_rst_err`.
- Frame start: in IDLE, on a clock with `i_ce`=1 and `o_full`=1:
  - HR moves to the shift register and `o_full` clears.
  - `i_length`, `i_stop2`, `i_parity` and `i_odd` are latched for the whole frame.
  - State goes to START.
  - A write on that same clock is accepted into the now-empty HR.
- States: IDLE → START → DATA → (PARITY if parity enabled) → STOP1 → (STOP2 if `i_stop2`) → IDLE or START.
- A bit counter counts `i_ce` pulses 0..`OVERSAMPLE`-1. State and bit index advance on the pulse where the count wraps.
- `o_tx` per state:
  - START: 0.
  - DATA: shift[0], LSB first. Shift right once per bit. Leave DATA after 6 + length bits.
  - PARITY: XOR of the sent data bits, XOR `odd`.
  - STOP1, STOP2, IDLE: 1.
- Back-to-back: at the end of the last stop bit with `o_full`=1, go directly to START with no idle bit. Reloading HR follows the frame-start rule.
- Configuration changes mid-frame have no effect until the next frame.
- `o_tx` is registered and glitch-free.

## Timing
- Reset values: `o_tx`=1, `o_full`=0, `o_busy`=0, `o_write_err`=0, state IDLE, counters 0, HR/shift 0.
- Reset mid-frame aborts the frame. `o_tx` returns high on the next clock and the HR content is discarded.
- Write-to-line latency from IDLE: the `i_we` edge sets `o_full`. `o_tx` falls on the edge of the first subsequent clock with `i_ce`=1.
- Each bit lasts exactly `OVERSAMPLE` `i_ce` pulses.
- Frame length in `i_ce` pulses: `OVERSAMPLE` × (1 + (6 + length) + parity + 1 + stop2). Example: 9 data bits, parity on, 2 stop bits = 13 bits = 104 pulses.
- `o_busy` rises together with the start bit. It falls on the edge ending the last stop bit, unless another frame follows.
- With `i_ce` held at 0, all state freezes. HR writes still work.

## Structure
- Shared package `uart_pkg`, also used by `uart_rx`, holds:
  - state enum (IDLE, START, DATA, PARITY, STOP1, STOP2);
  - `OVERSAMPLE` default;
  - a `data_bits(length)` function;
  - a `parity_bit(data, length, odd)` function.
- No sub-module: HR, FSM and counters sit in one module.

## Test plan
- Reset, then idle for 50 clocks → `o_tx`=1, `o_busy`=0, `o_full`=0 throughout.
- length=3, parity=1, odd=1, stop2=1, `i_ce`=1, write 9'b101010101 → `o_tx` sequence, 8 clocks per bit: 0, 1,0,1,0,1,0,1,0,1, parity 0, 1, 1. Total 104 clocks. `o_busy` falls at the end.
- length=0, parity=0, stop2=0, write 6'h2A, then write 6'h15 while the first frame is in flight → the two frames abut with no idle bit. `o_full` clears at the second frame's start.
- Three writes in quick succession while busy and HR full → third write dropped, `o_write_err`=1. `i_rst_err` pulse clears it.
- `i_ce` toggling every other clock → every bit lasts 16 clocks. `o_tx` is stable between `i_ce` pulses.
- Assert `i_rst` in the middle of the DATA state → next clock `o_tx`=1, `o_busy`=0, `o_full`=0. No resumed frame.
- Loopback of `o_tx` to `uart_rx` with matching config for all four lengths → received `o_data` equals the sent data, `o_parity_err`=0.
